// File: rtl/answer_table_if.sv
// Polling bus between the bus master and answer_table: address out, registered read data
// and the frame counter mirror back.
interface answer_table_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] frame;

  modport master (output addr, input data, input frame);
  modport slave  (input addr, output data, output frame);
endinterface

// File: rtl/answer_table.sv
// Answer register file: constant words, a ring of captured UART bytes and a frame counter.
// Define ANSWER_TABLE_OVF_EN to add a saturating ring-overflow counter at CAP_BASE+NUM_CAP.
module answer_table #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int NUM_CONST  = 15,
  parameter int CONST_STEP = 10,
  parameter int NUM_CAP    = 2,
  parameter int SETTLE     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValRX,
  input  logic [DATA_W-1:0] iUART,
  answer_table_if.slave     bus
);
  localparam int CAP_BASE = NUM_CONST + 1;
  localparam int LAST_CAP = CAP_BASE + NUM_CAP - 1;
  localparam int PTR_W    = (NUM_CAP > 1) ? $clog2(NUM_CAP) : 1;

  if (NUM_CAP < 1) begin : g_bad_num_cap
    $error("answer_table: NUM_CAP must be at least 1");
  end
  if (CAP_BASE + NUM_CAP > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("answer_table: capture ring does not fit in the address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} cap_state_e;

  logic              r_vs_meta, r_vs;
  cap_state_e        r_state;
  logic [3:0]        r_settle_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [DATA_W-1:0] r_ring [NUM_CAP];
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_frame;
  logic              r_armed;

  logic [31:0]       w_addr;
  logic              w_is_frame, w_is_const, w_is_cap, w_is_last;
  logic [PTR_W-1:0]  w_cap_idx;
  logic [DATA_W-1:0] w_const;
  logic              w_wr_en;

  assign w_addr     = 32'(bus.addr);
  assign w_is_frame = (w_addr == 32'd0);
  assign w_is_const = (w_addr != 32'd0) && (w_addr <= 32'(NUM_CONST));
  assign w_is_cap   = (w_addr >= 32'(CAP_BASE)) && (w_addr <= 32'(LAST_CAP));
  assign w_is_last  = (w_addr == 32'(LAST_CAP));
  assign w_cap_idx  = PTR_W'(w_addr - 32'(CAP_BASE));
  assign w_const    = DATA_W'(w_addr * 32'(CONST_STEP));
  assign w_wr_en    = (r_state == S_WAIT) && (r_settle_cnt == 4'd0);

  // NOTE: the synchroniser stages use non-blocking assignments so r_vs sees last cycle's
  // r_vs_meta; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_meta <= 1'b0;
      r_vs      <= 1'b0;
    end else begin
      r_vs_meta <= ValRX;
      r_vs      <= r_vs_meta;
    end
  end

  // One capture per high level of vs; a level that drops during WAIT is still written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 4'd0;
      r_wr_ptr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (r_vs) begin
          r_state      <= S_WAIT;
          r_settle_cnt <= 4'(SETTLE);
        end
        S_WAIT: if (r_settle_cnt == 4'd0) begin
          r_state  <= S_HOLD;
          r_wr_ptr <= (r_wr_ptr == PTR_W'(NUM_CAP - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        end else begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
        end
        S_HOLD: if (!r_vs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the ring is reset because its contents are software-visible and must read 0 after
  // reset; this keeps it in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAP; i++) r_ring[i] <= '0;
    end else if (w_wr_en) begin
      r_ring[r_wr_ptr] <= iUART;
    end
  end

`ifdef ANSWER_TABLE_OVF_EN
  logic [NUM_CAP-1:0] r_unread;
  logic [7:0]         r_ovf_cnt;
  logic               w_ovf_hit;

  // A slot read in the same cycle it is overwritten counts as consumed, not lost.
  assign w_ovf_hit = w_wr_en && r_unread[r_wr_ptr] && !(w_is_cap && (w_cap_idx == r_wr_ptr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unread  <= '0;
      r_ovf_cnt <= 8'd0;
    end else begin
      if (w_is_cap) r_unread[w_cap_idx] <= 1'b0;
      if (w_wr_en)  r_unread[r_wr_ptr]  <= 1'b1;
      if (w_is_frame)                          r_ovf_cnt <= 8'd0;
      else if (w_ovf_hit && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end
`endif

  // NOTE: there is deliberately no final else -- an unmatched address holds r_data. In a
  // clocked block that is just a register enable; the same shape in always_comb is a latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      if (w_is_frame)      r_data <= r_frame;
      else if (w_is_const) r_data <= w_const;
      else if (w_is_cap)   r_data <= r_ring[w_cap_idx];
`ifdef ANSWER_TABLE_OVF_EN
      else if (w_addr == 32'(LAST_CAP + 1)) r_data <= DATA_W'(r_ovf_cnt);
`endif
    end
  end

  // Reading the last ring slot counts one frame; reading addr 0 re-arms the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_armed <= 1'b1;
    end else if (w_is_frame) begin
      r_armed <= 1'b1;
    end else if (w_is_last && r_armed) begin
      r_frame <= r_frame + DATA_W'(1);
      r_armed <= 1'b0;
    end
  end

  assign bus.data  = r_data;
  assign bus.frame = r_frame;
endmodule

// File: tb/tb_answer_table.sv
// Self-checking bench for answer_table: directed scenarios plus randomized polling and UART
// traffic compared every cycle against a cycle-count based reference model.
module tb_answer_table;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int NUM_CAP  = 2;
  localparam int SETTLE   = 1;
  localparam int CAP_BASE = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              val_rx;
  logic [DATA_W-1:0] i_uart;
  logic              cmp_en;

  answer_table_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  answer_table #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CONST(15), .CONST_STEP(10),
    .NUM_CAP(NUM_CAP), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .ValRX(val_rx), .iUART(i_uart), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state advanced once per rising edge from the inputs present at that edge.
  int  m_data, m_frame, m_armed, m_ovf, m_wr, m_cyc, m_write_cyc;
  int  m_ring [NUM_CAP];
  bit  m_unread [NUM_CAP];
  bit  m_sync [2];
  bit  m_busy, m_written;

  task automatic model_reset();
    m_data = 0; m_frame = 0; m_armed = 1; m_ovf = 0; m_wr = 0; m_cyc = 0;
    m_write_cyc = 0; m_busy = 0; m_written = 0;
    m_sync[0] = 0; m_sync[1] = 0;
    for (int i = 0; i < NUM_CAP; i++) begin m_ring[i] = 0; m_unread[i] = 0; end
  endtask

  task automatic model_step();
    int a, rd_slot;
    bit vs;
    a = int'(bus.addr);
    rd_slot = -1;
    vs = m_sync[1];
    m_sync[1] = m_sync[0];
    m_sync[0] = val_rx;
    if (a == 0) begin
      m_data = m_frame; m_armed = 1; m_ovf = 0;
    end else if (a <= 15) begin
      m_data = (a * 10) % 256;
    end else if (a < CAP_BASE + NUM_CAP) begin
      rd_slot = a - CAP_BASE;
      m_data = m_ring[rd_slot];
      m_unread[rd_slot] = 0;
      if (a == CAP_BASE + NUM_CAP - 1 && m_armed == 1) begin
        m_frame = (m_frame + 1) % 256; m_armed = 0;
      end
    end
`ifdef ANSWER_TABLE_OVF_EN
    else if (a == CAP_BASE + NUM_CAP) m_data = m_ovf;
`endif
    // Capture lands SETTLE+1 cycles after the synced rise; re-arms only once vs is low again.
    if (!m_busy && vs) begin
      m_busy = 1; m_written = 0; m_write_cyc = m_cyc + SETTLE + 1;
    end else if (m_busy && !m_written && m_cyc == m_write_cyc) begin
`ifdef ANSWER_TABLE_OVF_EN
      if (m_unread[m_wr] && rd_slot != m_wr && a != 0 && m_ovf < 255) m_ovf++;
`endif
      m_ring[m_wr] = int'(i_uart);
      m_unread[m_wr] = 1;
      m_wr = (m_wr + 1) % NUM_CAP;
      m_written = 1;
    end else if (m_busy && m_written && !vs) begin
      m_busy = 0;
    end
    m_cyc++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("data_vs_model", 32'(bus.data), 32'(m_data));
      check("frame_vs_model", 32'(bus.frame), 32'(m_frame));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int a);
    bus.addr = ADDR_W'(a);
    cycles(1);
  endtask

  task automatic capture(input logic [7:0] v);
    i_uart = v; val_rx = 1'b1;
    cycles(7);
    val_rx = 1'b0;
    cycles(4);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_data"}, 32'(bus.data), 32'd0);
    check({tag, "_frame"}, 32'(bus.frame), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; val_rx = 1'b0; i_uart = '0; bus.addr = '0; cmp_en = 1'b0;
    cycles(3);
    rst = 1'b0; cmp_en = 1'b1;
    check("reset_data", 32'(bus.data), 32'd0);

    set_addr(5);
    check("const5_pre_reset", 32'(bus.data), 32'd50);
    async_reset("rst_mid");

    set_addr(1);  check("const1", 32'(bus.data), 32'd10);
    set_addr(7);  check("const7", 32'(bus.data), 32'd70);
    set_addr(15); check("const15", 32'(bus.data), 32'd150);
    set_addr(16); check("ring0_reset", 32'(bus.data), 32'd0);

    bus.addr = 5'd17; cycles(20);
    check("frame_once", 32'(bus.frame), 32'd1);
    set_addr(0); check("addr0_frame", 32'(bus.data), 32'd1);
    set_addr(17); cycles(1);
    check("frame_rearm", 32'(bus.frame), 32'd2);

    bus.addr = 5'd3;
    capture(8'h52); set_addr(16); check("cap_52", 32'(bus.data), 32'h52);
    bus.addr = 5'd3;
    capture(8'hA5); set_addr(17); check("cap_A5", 32'(bus.data), 32'hA5);
    bus.addr = 5'd3;
    capture(8'h11); set_addr(16); check("cap_wrap", 32'(bus.data), 32'h11);
    check("frame_no_rearm", 32'(bus.frame), 32'd2);

    for (int i = 0; i < 253; i++) begin set_addr(0); set_addr(17); end
    cycles(1);
    check("frame_255", 32'(bus.frame), 32'd255);
    set_addr(0); set_addr(17); cycles(1);
    check("frame_wrap", 32'(bus.frame), 32'd0);

    // wr_ptr is at slot 1: fill it, then overwrite slot 0 while polling it.
    bus.addr = 5'd3;
    capture(8'h33);
    bus.addr = 5'd16; i_uart = 8'h7E; val_rx = 1'b1;
    cycles(5); check("race_old", 32'(bus.data), 32'h11);
    cycles(1); check("race_new", 32'(bus.data), 32'h7E);
    cycles(1); val_rx = 1'b0; cycles(4);

`ifdef ANSWER_TABLE_OVF_EN
    set_addr(0); set_addr(17); set_addr(16);
    bus.addr = 5'd3;
    capture(8'h01); capture(8'h02); capture(8'h03);
    set_addr(18); check("ovf_one", 32'(bus.data), 32'd1);
    set_addr(0); set_addr(18); check("ovf_clear", 32'(bus.data), 32'd0);
`else
    set_addr(16); set_addr(18); check("hold_addr18", 32'(bus.data), 32'h7E);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.addr = ADDR_W'($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) val_rx = ~val_rx;
      if (!val_rx) i_uart = DATA_W'($urandom);
      cycles(1);
    end
    val_rx = 1'b0;
    cycles(6);

    async_reset("rst_end");
    set_addr(16); check("ring0_after_rst", 32'(bus.data), 32'd0);
    set_addr(17); check("ring1_after_rst", 32'(bus.data), 32'd0);
    set_addr(0);  check("frame_after_rst", 32'(bus.data), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
